freq_div_ctrl: RTL and testbench

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

---
 rtl/freq_div_pkg.sv | 12 +
 rtl/freq_div_counter.sv | 42 ++++
 rtl/freq_div_ctrl.sv | 108 ++++++++++
 tb/tb_freq_div_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and FSM encoding for the clock-divider controller.
package freq_div_pkg;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 2;
  localparam int MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;
endpackage

// File: rtl/freq_div_counter.sv
// Period counter with wrap detect; tick/div_clk are registered from the next count and next ratio,
// so they always describe the count held after the same edge.
module freq_div_counter #(
  parameter int DIV_W = freq_div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             active_next,
  input  logic [DIV_W-1:0] div_reg,
  input  logic [DIV_W-1:0] div_next,
  output logic             wrap,
  output logic             tick,
  output logic             div_clk
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;

  assign wrap = active && (cnt == div_reg - ONE);

  // Leaving IDLE, wrapping, or returning to IDLE all land on zero.
  always_comb begin
    cnt_next = '0;
    if (active && !wrap) begin
      cnt_next = cnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      tick    <= active_next && (cnt_next == div_next - ONE);
      div_clk <= active_next && (cnt_next >= (div_next >> 1));
    end
  end
endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable clock divider: FSM and ratio handshake; ratio changes and stops take effect
// only at a period boundary so div_clk never produces a short phase.
module freq_div_ctrl #(
  parameter int DIV_W   = freq_div_pkg::DIV_W,
  parameter int DEF_DIV = freq_div_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             div_clk,
  output logic             busy,
  output logic [1:0]       state
);
  import freq_div_pkg::*;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_reg, div_d;
  logic [DIV_W-1:0] pend_div, pend_d;
  logic             stop_pend, stop_d;
  logic             wrap;
  logic             xfer;
  logic             legal;

  assign xfer  = cfg_valid && cfg_ready;
  assign legal = cfg_div >= DIV_W'(MIN_DIV);
  assign busy  = (state_q != IDLE);
  assign state = state_q;

  // A stopping wrap edge refuses new ratios so none is acknowledged and then lost.
  always_comb begin
    cfg_ready = 1'b0;
    case (state_q)
      IDLE:    cfg_ready = 1'b1;
      RUN:     cfg_ready = !(stop_pend && wrap);
      default: cfg_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_reg;
    pend_d  = pend_div;
    stop_d  = stop_pend;
    case (state_q)
      IDLE: begin
        if (xfer && legal) div_d = cfg_div;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) stop_d = 1'b1;
        if (stop_pend && wrap) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (xfer && legal) begin
          pend_d  = cfg_div;
          state_d = PEND;
        end
      end
      PEND: begin
        if (stop) stop_d = 1'b1;
        if (wrap) begin
          div_d = pend_div;
          if (stop_pend) begin
            state_d = IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      div_reg   <= DIV_W'(DEF_DIV);
      pend_div  <= DIV_W'(DEF_DIV);
      stop_pend <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_reg   <= div_d;
      pend_div  <= pend_d;
      stop_pend <= stop_d;
      cfg_err   <= xfer && !legal;
    end
  end

  freq_div_counter #(.DIV_W(DIV_W)) u_counter (
    .clk         (clk),
    .rst         (reset_in),
    .active      (state_q != IDLE),
    .active_next (state_d != IDLE),
    .div_reg     (div_reg),
    .div_next    (div_d),
    .wrap        (wrap),
    .tick        (tick),
    .div_clk     (div_clk)
  );
endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl; outputs sampled on the falling edge.
module tb_freq_div_ctrl;
  logic       clk = 1'b0;
  logic       reset_in;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       tick;
  logic       div_clk;
  logic       busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freq_div_ctrl #(.DIV_W(8), .DEF_DIV(2)) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .div_clk   (div_clk),
    .busy      (busy),
    .state     (state)
  );

  task automatic go_idle();
    int n;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL go_idle_timeout busy=%b want 0", busy);
    end
  endtask

  task automatic launch(input logic [7:0] n);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = n;
    start     = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", tick); end
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL rst_div_clk got %b want 0", div_clk); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got %b want 0", cfg_err); end
    @(negedge clk);
    reset_in = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_div4();
    logic exp_dc, exp_tk;
    launch(8'd4);
    for (int i = 0; i < 12; i++) begin
      exp_dc = ((i % 4) >= 2);
      exp_tk = ((i % 4) == 3);
      checks++; if (div_clk !== exp_dc) begin errors++; $display("FAIL div4_div_clk i=%0d got %b want %b", i, div_clk, exp_dc); end
      checks++; if (tick !== exp_tk) begin errors++; $display("FAIL div4_tick i=%0d got %b want %b", i, tick, exp_tk); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div4_busy got %b want 1", busy); end
    go_idle();
  endtask

  task automatic test_div3();
    logic exp_dc, exp_tk;
    launch(8'd3);
    for (int i = 0; i < 9; i++) begin
      exp_dc = ((i % 3) >= 1);
      exp_tk = ((i % 3) == 2);
      checks++; if (div_clk !== exp_dc) begin errors++; $display("FAIL div3_div_clk i=%0d got %b want %b", i, div_clk, exp_dc); end
      checks++; if (tick !== exp_tk) begin errors++; $display("FAIL div3_tick i=%0d got %b want %b", i, tick, exp_tk); end
      @(negedge clk);
    end
    go_idle();
  endtask

  task automatic test_ratio_change();
    logic exp_dc, exp_tk;
    launch(8'd4);
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL chg_ready_run got %b want 1", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL chg_state_pend got %0d want 2", state); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL chg_ready_pend got %b want 0", cfg_ready); end
    checks++; if (div_clk !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL chg_cnt2 got dc=%b tk=%b want dc=1 tk=0", div_clk, tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL chg_cnt3 got tk=%b st=%0d want tk=1 st=2", tick, state); end
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL chg_state_run got %0d want 1", state); end
    for (int i = 0; i < 12; i++) begin
      exp_dc = ((i % 6) >= 3);
      exp_tk = ((i % 6) == 5);
      checks++; if (div_clk !== exp_dc) begin errors++; $display("FAIL div6_div_clk i=%0d got %b want %b", i, div_clk, exp_dc); end
      checks++; if (tick !== exp_tk) begin errors++; $display("FAIL div6_tick i=%0d got %b want %b", i, tick, exp_tk); end
      @(negedge clk);
    end
  endtask

  task automatic test_bad_cfg();
    int p;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse got %b want 1", cfg_err); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bad_state got %0d want 1", state); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got %b want 0", cfg_err); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bad_state2 got %0d want 1", state); end
    p = 0;
    while (tick !== 1'b1 && p < 20) begin @(negedge clk); p++; end
    @(negedge clk);
    p = 1;
    while (tick !== 1'b1 && p < 20) begin @(negedge clk); p++; end
    checks++; if (p != 6) begin errors++; $display("FAIL bad_period got %0d want 6", p); end
    go_idle();
  endtask

  task automatic test_stop();
    launch(8'd5);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (busy !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL stop_cnt2 got busy=%b tk=%b want 1 0", busy, tick); end
    @(negedge clk);
    checks++; if (div_clk !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL stop_cnt3 got dc=%b tk=%b want 1 0", div_clk, tick); end
    @(negedge clk);
    checks++; if (tick !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL stop_cnt4 got tk=%b busy=%b want 1 1", tick, busy); end
    @(negedge clk);
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL stop_idle got st=%0d busy=%b want 0 0", state, busy); end
    checks++; if (div_clk !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL stop_outs got dc=%b tk=%b want 0 0", div_clk, tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_stop_vs_cfg();
    launch(8'd2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (cfg_ready !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL svc_ready got rdy=%b st=%0d want 0 1", cfg_ready, state); end
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (state !== 2'd0 || cfg_err !== 1'b0) begin errors++; $display("FAIL svc_idle got st=%0d err=%b want 0 0", state, cfg_err); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (div_clk !== i[0] || tick !== i[0]) begin errors++; $display("FAIL svc_ratio i=%0d got dc=%b tk=%b want %b", i, div_clk, tick, i[0]); end
      @(negedge clk);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_pend();
    launch(8'd4);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (state !== 2'd2 || div_clk !== 1'b1) begin errors++; $display("FAIL mid_pre got st=%0d dc=%b want 2 1", state, div_clk); end
    #2;
    reset_in = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_state got st=%0d busy=%b want 0 0", state, busy); end
    checks++; if (div_clk !== 1'b0 || tick !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got dc=%b tk=%b err=%b want 0 0 0", div_clk, tick, cfg_err); end
    @(negedge clk);
    reset_in = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL mid_restart got %0d want 1", state); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (div_clk !== i[0] || tick !== i[0]) begin errors++; $display("FAIL mid_ratio2 i=%0d got dc=%b tk=%b want %b", i, div_clk, tick, i[0]); end
      @(negedge clk);
    end
    go_idle();
  endtask

  initial begin
    reset_in  = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    test_reset();
    test_div4();
    test_div3();
    test_ratio_change();
    test_bad_cfg();
    test_stop();
    test_stop_vs_cfg();
    test_reset_mid_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
